// File: rtl/sm83_flags_ctl_pkg.sv
// Shared types for the SM83 flag-update sequencer.
// Holds the opcode and state enums, the strobe bundle and a legality helper.
// No logic here: the decoder and the FSM use these types.
package sm83_flags_ctl_pkg;

    // Values 8..15 are not named: they decode as illegal opcodes.
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ALU     = 4'd1,
        OP_INCDEC  = 4'd2,
        OP_ADD16   = 4'd3,
        OP_ROT     = 4'd4,
        OP_DAA     = 4'd5,
        OP_POP_AF  = 4'd6,
        OP_PUSH_AF = 4'd7
    } flags_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } flags_state_t;

    // Every per-cycle control line that goes to the flags register or its datapath.
    typedef struct packed {
        logic flags_bus;
        logic flags_alu;
        logic flags_loop;
        logic flags_oe;
        logic zero_we;
        logic zero_clr;
        logic half_carry_we;
        logic half_carry_set;
        logic half_carry_cpl;
        logic daa_carry_we;
        logic neg_we;
        logic neg_set;
        logic neg_clr;
        logic carry_we;
        logic carry_set;
        logic carry_cpl;
        logic sec_carry_we;
        logic sec_carry_sh;
        logic sec_carry_daa;
        logic sec_carry_sel;
    } flags_strobe_t;

    localparam flags_strobe_t FLAGS_STROBE_NONE = '0;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op < 4'd8);
    endfunction

endpackage

// File: rtl/sm83_flags_ctl_if.sv
// Command handshake and flags-register strobe bundle for sm83_flags_ctl.
// master = control unit side (offers commands), slave = sequencer side.
// cmd_ready/cmd_valid form the only handshake; strobes have no flow control.
interface sm83_flags_ctl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       flags_loop;
    logic       flags_oe;
    logic       flags_bus;
    logic       flags_alu;
    logic       zero_we;
    logic       zero_clr;
    logic       half_carry_we;
    logic       half_carry_set;
    logic       half_carry_cpl;
    logic       daa_carry_we;
    logic       neg_we;
    logic       neg_set;
    logic       neg_clr;
    logic       carry_we;
    logic       sec_carry_we;
    logic       sec_carry_sh;
    logic       sec_carry_daa;
    logic       sec_carry_sel;
    logic       carry_set;
    logic       carry_cpl;

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, busy, done, illegal, flags_loop, flags_oe,
        input  flags_bus, flags_alu, zero_we, zero_clr, half_carry_we,
        input  half_carry_set, half_carry_cpl, daa_carry_we, neg_we, neg_set,
        input  neg_clr, carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa,
        input  sec_carry_sel, carry_set, carry_cpl
    );

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, busy, done, illegal, flags_loop, flags_oe,
        output flags_bus, flags_alu, zero_we, zero_clr, half_carry_we,
        output half_carry_set, half_carry_cpl, daa_carry_we, neg_we, neg_set,
        output neg_clr, carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa,
        output sec_carry_sel, carry_set, carry_cpl
    );
endinterface

// File: rtl/sm83_flags_ctl_decode.sv
// Step decoder: (registered op, state) -> flags strobes, last-step and illegal flags.
// Purely combinational, zero latency.
// No backpressure; IDLE always yields no strobes.
module sm83_flags_ctl_decode
    import sm83_flags_ctl_pkg::*;
(
    input  flags_op_t     op,
    input  flags_state_t  state,
    output flags_strobe_t strb,
    output logic          last,
    output logic          illegal
);

    // Per-op step table; single-step ops treat any active state as their last step.
    always_comb begin
        strb    = FLAGS_STROBE_NONE;
        last    = 1'b0;
        illegal = 1'b0;
        if (state != ST_IDLE) begin
            case (op)
                OP_NOP: last = 1'b1;
                OP_ALU, OP_INCDEC: begin
                    strb.flags_alu     = 1'b1;
                    strb.zero_we       = 1'b1;
                    strb.neg_we        = 1'b1;
                    strb.half_carry_we = 1'b1;
                    strb.daa_carry_we  = 1'b1;
                    strb.carry_we      = (op == OP_ALU);
                    last               = 1'b1;
                end
                OP_ADD16: begin
                    // Low byte only chains the carry; high byte settles H, C and clears N.
                    strb.flags_alu = 1'b1;
                    strb.carry_we  = 1'b1;
                    if (state != ST_S1) begin
                        strb.half_carry_we = 1'b1;
                        strb.neg_we        = 1'b1;
                        strb.neg_clr       = 1'b1;
                        last               = 1'b1;
                    end
                end
                OP_ROT, OP_DAA: begin
                    case (state)
                        ST_S1: begin
                            strb.sec_carry_we  = 1'b1;
                            strb.sec_carry_sh  = (op == OP_ROT);
                            strb.sec_carry_daa = (op == OP_DAA);
                        end
                        ST_S2: begin
                            strb.flags_alu     = 1'b1;
                            strb.zero_we       = 1'b1;
                            strb.half_carry_we = 1'b1;
                            if (op == OP_ROT) begin
                                strb.zero_clr = 1'b1;
                                strb.neg_we   = 1'b1;
                                strb.neg_clr  = 1'b1;
                            end
                        end
                        default: begin
                            // Commit the secondary carry into the primary carry via the loopback.
                            strb.sec_carry_sel = 1'b1;
                            strb.flags_loop    = 1'b1;
                            strb.flags_bus     = 1'b1;
                            strb.carry_we      = 1'b1;
                            last               = 1'b1;
                        end
                    endcase
                end
                OP_POP_AF: begin
                    strb.flags_bus     = 1'b1;
                    strb.zero_we       = 1'b1;
                    strb.neg_we        = 1'b1;
                    strb.half_carry_we = 1'b1;
                    strb.carry_we      = 1'b1;
                    last               = 1'b1;
                end
                OP_PUSH_AF: begin
                    strb.flags_oe = 1'b1;
                    last          = 1'b1;
                end
                default: begin
                    illegal = !op_is_legal(op);
                    last    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sm83_flags_ctl.sv
// Flag-update sequencer: one command per instruction, 1-3 strobe cycles per command.
// Latency: command accepted at edge k drives its first step in cycle k..k+1.
// Backpressure: cmd_ready only in IDLE or on a last step (back-to-back with no bubble).
module sm83_flags_ctl
    import sm83_flags_ctl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    sm83_flags_ctl_if.slave    bus
);

    flags_state_t  state_q, state_d;
    flags_op_t     op_q;
    flags_strobe_t strb;
    logic          last;
    logic          illegal;
    logic          ready;
    logic          accept;

    sm83_flags_ctl_decode u_decode (
        .op      (op_q),
        .state   (state_q),
        .strb    (strb),
        .last    (last),
        .illegal (illegal)
    );

    assign ready  = (state_q == ST_IDLE) || last;
    assign accept = bus.cmd_valid && ready;

    // Next state: start S1 on accept, step through the sequence, fall to IDLE after the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_S1;
            ST_S1:   state_d = last ? (accept ? ST_S1 : ST_IDLE) : ST_S2;
            ST_S2:   state_d = last ? (accept ? ST_S1 : ST_IDLE) : ST_S3;
            default: state_d = accept ? ST_S1 : ST_IDLE;
        endcase
    end

    // State and opcode registers; opcode is captured only on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= flags_op_t'(bus.cmd_op);
        end
    end

    assign bus.cmd_ready      = ready;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = last;
    assign bus.illegal        = illegal;
    assign bus.flags_loop     = strb.flags_loop;
    assign bus.flags_oe       = strb.flags_oe;
    assign bus.flags_bus      = strb.flags_bus;
    assign bus.flags_alu      = strb.flags_alu;
    assign bus.zero_we        = strb.zero_we;
    assign bus.zero_clr       = strb.zero_clr;
    assign bus.half_carry_we  = strb.half_carry_we;
    assign bus.half_carry_set = strb.half_carry_set;
    assign bus.half_carry_cpl = strb.half_carry_cpl;
    assign bus.daa_carry_we   = strb.daa_carry_we;
    assign bus.neg_we         = strb.neg_we;
    assign bus.neg_set        = strb.neg_set;
    assign bus.neg_clr        = strb.neg_clr;
    assign bus.carry_we       = strb.carry_we;
    assign bus.sec_carry_we   = strb.sec_carry_we;
    assign bus.sec_carry_sh   = strb.sec_carry_sh;
    assign bus.sec_carry_daa  = strb.sec_carry_daa;
    assign bus.sec_carry_sel  = strb.sec_carry_sel;
    assign bus.carry_set      = strb.carry_set;
    assign bus.carry_cpl      = strb.carry_cpl;

    // Register exclusivity: one data source per written flag unless a set/clr supplies the value.
    logic src_one;
    logic sec_src_one;
    assign src_one     = $onehot({strb.flags_bus, strb.flags_alu});
    assign sec_src_one = $onehot({strb.sec_carry_sh, strb.sec_carry_daa});

    a_bus_alu_excl: assert property (@(posedge clk) disable iff (reset)
        !(strb.flags_bus && strb.flags_alu));
    a_carry_excl: assert property (@(posedge clk) disable iff (reset)
        !(strb.carry_we && strb.sec_carry_we));
    a_zero_src: assert property (@(posedge clk) disable iff (reset)
        !strb.zero_we || src_one || strb.zero_clr);
    a_half_src: assert property (@(posedge clk) disable iff (reset)
        !strb.half_carry_we || src_one || strb.half_carry_set || strb.half_carry_cpl);
    a_neg_src: assert property (@(posedge clk) disable iff (reset)
        !strb.neg_we || src_one || strb.neg_set || strb.neg_clr);
    a_carry_src: assert property (@(posedge clk) disable iff (reset)
        !strb.carry_we || src_one || strb.carry_set || strb.carry_cpl);
    a_daa_src: assert property (@(posedge clk) disable iff (reset)
        !strb.daa_carry_we || src_one);
    a_sec_src: assert property (@(posedge clk) disable iff (reset)
        !strb.sec_carry_we || sec_src_one);

endmodule

// File: tb/tb_sm83_flags_ctl.sv
// Directed + random bench for sm83_flags_ctl with a per-cycle expected-output scoreboard.
module tb_sm83_flags_ctl;
    import sm83_flags_ctl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sm83_flags_ctl_if bus ();

    sm83_flags_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          illegal;
        flags_strobe_t s;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   dones = 0;
    int   busy_cyc = 0;
    int   model_cyc = 0;

    // Small flags-register model: shift-out = 1, ALU carry_in = 0, bus carry = 0, DAA carry = 0.
    logic fc, sc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fc <= 1'b0;
            sc <= 1'b0;
        end else begin
            if (bus.sec_carry_we) sc <= bus.sec_carry_sh ? 1'b1 : 1'b0;
            if (bus.carry_we)     fc <= bus.sec_carry_sel ? sc : 1'b0;
        end
    end

    function automatic obs_t observe();
        obs_t o;
        o.busy = bus.busy;                   o.done = bus.done;
        o.illegal = bus.illegal;             o.s.flags_bus = bus.flags_bus;
        o.s.flags_alu = bus.flags_alu;       o.s.flags_loop = bus.flags_loop;
        o.s.flags_oe = bus.flags_oe;         o.s.zero_we = bus.zero_we;
        o.s.zero_clr = bus.zero_clr;         o.s.half_carry_we = bus.half_carry_we;
        o.s.half_carry_set = bus.half_carry_set;
        o.s.half_carry_cpl = bus.half_carry_cpl;
        o.s.daa_carry_we = bus.daa_carry_we; o.s.neg_we = bus.neg_we;
        o.s.neg_set = bus.neg_set;           o.s.neg_clr = bus.neg_clr;
        o.s.carry_we = bus.carry_we;         o.s.carry_set = bus.carry_set;
        o.s.carry_cpl = bus.carry_cpl;       o.s.sec_carry_we = bus.sec_carry_we;
        o.s.sec_carry_sh = bus.sec_carry_sh; o.s.sec_carry_daa = bus.sec_carry_daa;
        o.s.sec_carry_sel = bus.sec_carry_sel;
        return o;
    endfunction

    function automatic int nsteps(input logic [3:0] op);
        if (op == 4'd3) return 2;
        if (op == 4'd4 || op == 4'd5) return 3;
        return 1;
    endfunction

    // Expected outputs for step n (1-based) of opcode op, written from the command table.
    function automatic obs_t exp_step(input logic [3:0] op, input int n);
        obs_t e = '0;
        e.busy = 1'b1;
        e.done = (n == nsteps(op));
        case (op)
            4'd1, 4'd2: begin
                e.s.flags_alu = 1; e.s.zero_we = 1; e.s.neg_we = 1;
                e.s.half_carry_we = 1; e.s.daa_carry_we = 1; e.s.carry_we = (op == 4'd1);
            end
            4'd3: begin
                e.s.flags_alu = 1; e.s.carry_we = 1;
                if (n == 2) begin e.s.half_carry_we = 1; e.s.neg_we = 1; e.s.neg_clr = 1; end
            end
            4'd4, 4'd5: begin
                if (n == 1) begin
                    e.s.sec_carry_we = 1;
                    if (op == 4'd4) e.s.sec_carry_sh = 1; else e.s.sec_carry_daa = 1;
                end else if (n == 2) begin
                    e.s.flags_alu = 1; e.s.zero_we = 1; e.s.half_carry_we = 1;
                    if (op == 4'd4) begin e.s.zero_clr = 1; e.s.neg_we = 1; e.s.neg_clr = 1; end
                end else begin
                    e.s.sec_carry_sel = 1; e.s.flags_loop = 1; e.s.flags_bus = 1; e.s.carry_we = 1;
                end
            end
            4'd6: begin
                e.s.flags_bus = 1; e.s.zero_we = 1; e.s.neg_we = 1;
                e.s.half_carry_we = 1; e.s.carry_we = 1;
            end
            4'd7: e.s.flags_oe = 1;
            4'd0: ;
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle, entered 1 time unit after a rising edge: check this cycle, drive next.
    task automatic cycle(input logic v, input logic [3:0] op, input string tag);
        obs_t e;
        logic rdy;
        e = (exp_q.size() != 0) ? exp_q[0] : obs_t'('0);
        rdy = (exp_q.size() == 0) || e.done;
        chk(tag, 32'(observe()), 32'(e));
        chk({tag, "_rdy"}, 32'(bus.cmd_ready), 32'(rdy));
        dones    += int'(bus.done);
        busy_cyc += int'(bus.busy);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        if (v && rdy) begin
            accepts++;
            model_cyc += nsteps(op);
            for (int n = 1; n <= nsteps(op); n++) exp_q.push_back(exp_step(op, n));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(observe()), 32'd0);
        #4 reset = 1'b0;
        @(posedge clk);
        #1;

        // ALU single cycle, then idle
        cycle(1'b1, 4'd1, "alu_accept");
        cycle(1'b0, 4'd0, "alu_s1");
        cycle(1'b0, 4'd0, "alu_idle");

        // ADD16 then INCDEC held valid: accepted on ADD16's last step, no bubble
        cycle(1'b1, 4'd3, "add16_accept");
        cycle(1'b1, 4'd2, "add16_s1");
        cycle(1'b1, 4'd2, "add16_s2");
        cycle(1'b0, 4'd0, "incdec_s1");
        cycle(1'b0, 4'd0, "incdec_idle");

        // ROT: three steps; the register model ends with carry = shifted-out 1
        cycle(1'b1, 4'd4, "rot_accept");
        cycle(1'b1, 4'd9, "rot_s1");
        cycle(1'b0, 4'd9, "rot_s2");
        cycle(1'b0, 4'd0, "rot_s3");
        cycle(1'b0, 4'd0, "rot_idle");
        chk("rot_carry_commit", 32'(fc), 32'd1);

        // DAA interrupted by reset during S2: outputs drop immediately, nothing replayed
        cycle(1'b1, 4'd5, "daa_accept");
        cycle(1'b0, 4'd0, "daa_s1");
        chk("daa_s2_pre_reset", 32'(observe()), 32'(exp_step(4'd5, 2)));
        #2 reset = 1'b1;
        #1 chk("daa_reset_outputs", 32'(observe()), 32'd0);
        exp_q.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 4'd6, "pop_accept");
        cycle(1'b0, 4'd0, "pop_s1");
        cycle(1'b0, 4'd0, "pop_idle");

        // Illegal opcode 12, then PUSH_AF
        cycle(1'b1, 4'd12, "ill_accept");
        cycle(1'b1, 4'd7, "ill_s1");
        cycle(1'b0, 4'd0, "push_s1");
        cycle(1'b0, 4'd0, "push_idle");

        // Random stream: per-cycle scoreboard plus done/accept and busy-cycle totals
        accepts = 0; dones = 0; busy_cyc = 0; model_cyc = 0;
        for (int i = 0; i < 60000 && accepts < 10000; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
        chk("rand_accept_count", 32'(accepts), 32'd10000);
        repeat (4) cycle(1'b0, 4'd0, "drain");
        chk("done_eq_accept", 32'(dones), 32'(accepts));
        chk("busy_cycles", 32'(busy_cyc), 32'(model_cyc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
